prco_exec: RTL and testbench

PRCO_EXEC -- requirements
Module: prco_exec

---
 rtl/prco_exec.sv | 176 +++++++++++++++++
 tb/tb_prco_exec.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prco_exec.sv
// prco_exec: execute stage of the PRCO pipeline. Single-cycle ALU ops, a 17-cycle
// shift-add multiplier, and branch resolution with a one-cycle wrong-path squash.
module prco_exec (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_p_valid,
  output logic        q_p_stalled,
  output logic        q_p_valid,
  input  logic        i_p_stalled,
  output logic        q_p_cp,
  input  logic [5:0]  i_op,
  input  logic [2:0]  i_seld,
  input  logic [15:0] i_data_a,
  input  logic [15:0] i_data_b,
  input  logic [15:0] i_imm8,
  output logic [15:0] q_result,
  output logic [2:0]  q_seld,
  output logic        q_we,
  output logic [2:0]  q_flags,
  output logic [15:0] q_branch_pc
);
  localparam logic [5:0] OP_MOV = 6'h01;
  localparam logic [5:0] OP_ADD = 6'h02;
  localparam logic [5:0] OP_SUB = 6'h03;
  localparam logic [5:0] OP_AND = 6'h04;
  localparam logic [5:0] OP_OR  = 6'h05;
  localparam logic [5:0] OP_XOR = 6'h06;
  localparam logic [5:0] OP_SHL = 6'h07;
  localparam logic [5:0] OP_SHR = 6'h08;
  localparam logic [5:0] OP_MUL = 6'h09;
  localparam logic [5:0] OP_CMP = 6'h0A;
  localparam logic [5:0] OP_JMP = 6'h0B;
  localparam logic [5:0] OP_JEQ = 6'h0C;
  localparam logic [5:0] OP_JNE = 6'h0D;

  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
  state_t state_reg, state_next;

  logic [15:0] mul_a_reg, mul_b_reg, mul_acc_reg;
  logic [3:0]  mul_cnt_reg;
  logic [2:0]  mul_seld_reg;
  logic        accept;

  logic [15:0] alu_result;
  logic        alu_carry, alu_upd_zn, alu_upd_c, alu_we, alu_valid, alu_taken;
  logic [16:0] add_wide, sub_wide, shl_wide, shr_wide;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept && i_op == OP_MUL) state_next = S_MUL;
      S_MUL:   if (mul_cnt_reg == 4'd15) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A pending q_p_cp means the instruction now presented is wrong-path: drop it.
  always_comb begin
    q_p_stalled = (state_reg != S_IDLE) || (q_p_valid && i_p_stalled);
    accept      = i_p_valid && !q_p_stalled && !q_p_cp;
  end

  always_comb begin
    add_wide   = {1'b0, i_data_a} + {1'b0, i_data_b};
    sub_wide   = {1'b0, i_data_a} - {1'b0, i_data_b};
    // Extra bit on the shifted-out side captures the last bit lost (0 for shift 0).
    shl_wide   = {1'b0, i_data_a} << i_data_b[3:0];
    shr_wide   = {i_data_a, 1'b0} >> i_data_b[3:0];
    alu_result = q_result;
    alu_carry  = 1'b0;
    alu_upd_zn = 1'b0;
    alu_upd_c  = 1'b0;
    alu_we     = 1'b0;
    alu_valid  = 1'b1;
    alu_taken  = 1'b0;
    case (i_op)
      OP_MOV: begin alu_result = i_imm8; alu_we = 1'b1; end
      OP_ADD: begin
        alu_result = add_wide[15:0]; alu_carry = add_wide[16];
        alu_upd_zn = 1'b1; alu_upd_c = 1'b1; alu_we = 1'b1;
      end
      OP_SUB: begin
        alu_result = sub_wide[15:0]; alu_carry = sub_wide[16];
        alu_upd_zn = 1'b1; alu_upd_c = 1'b1; alu_we = 1'b1;
      end
      OP_AND: begin alu_result = i_data_a & i_data_b; alu_upd_zn = 1'b1; alu_we = 1'b1; end
      OP_OR:  begin alu_result = i_data_a | i_data_b; alu_upd_zn = 1'b1; alu_we = 1'b1; end
      OP_XOR: begin alu_result = i_data_a ^ i_data_b; alu_upd_zn = 1'b1; alu_we = 1'b1; end
      OP_SHL: begin
        alu_result = shl_wide[15:0]; alu_carry = shl_wide[16];
        alu_upd_zn = 1'b1; alu_upd_c = 1'b1; alu_we = 1'b1;
      end
      OP_SHR: begin
        alu_result = shr_wide[16:1]; alu_carry = shr_wide[0];
        alu_upd_zn = 1'b1; alu_upd_c = 1'b1; alu_we = 1'b1;
      end
      OP_MUL: alu_valid = 1'b0;
      OP_CMP: begin
        alu_result = sub_wide[15:0]; alu_carry = sub_wide[16];
        alu_upd_zn = 1'b1; alu_upd_c = 1'b1;
      end
      OP_JMP: alu_taken = 1'b1;
      OP_JEQ: alu_taken = q_flags[FLAG_Z];
      OP_JNE: alu_taken = !q_flags[FLAG_Z];
      default: ;
    endcase
    if (alu_taken) alu_valid = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      q_p_valid    <= 1'b0;
      q_p_cp       <= 1'b0;
      q_we         <= 1'b0;
      q_result     <= 16'h0000;
      q_seld       <= 3'd0;
      q_flags      <= 3'd0;
      q_branch_pc  <= 16'h0000;
      mul_a_reg    <= 16'h0000;
      mul_b_reg    <= 16'h0000;
      mul_acc_reg  <= 16'h0000;
      mul_cnt_reg  <= 4'd0;
      mul_seld_reg <= 3'd0;
    end else begin
      q_p_cp <= 1'b0;
      if (state_reg == S_MUL) begin
        if (mul_b_reg[0]) mul_acc_reg <= mul_acc_reg + mul_a_reg;
        mul_a_reg   <= mul_a_reg << 1;
        mul_b_reg   <= mul_b_reg >> 1;
        mul_cnt_reg <= mul_cnt_reg + 4'd1;
      end
      if (state_reg == S_DONE) begin
        q_p_valid       <= 1'b1;
        q_we            <= 1'b1;
        q_result        <= mul_acc_reg;
        q_seld          <= mul_seld_reg;
        q_flags[FLAG_N] <= mul_acc_reg[15];
        q_flags[FLAG_Z] <= (mul_acc_reg == 16'h0000);
      end else if (accept) begin
        q_p_valid <= alu_valid;
        q_we      <= alu_we && alu_valid;
        q_result  <= alu_result;
        q_seld    <= i_seld;
        if (alu_upd_zn) begin
          q_flags[FLAG_N] <= alu_result[15];
          q_flags[FLAG_Z] <= (alu_result == 16'h0000);
        end
        if (alu_upd_c) q_flags[FLAG_C] <= alu_carry;
        if (alu_taken) begin
          q_p_cp      <= 1'b1;
          q_branch_pc <= i_imm8;
        end
        if (i_op == OP_MUL) begin
          mul_a_reg    <= i_data_a;
          mul_b_reg    <= i_data_b;
          mul_acc_reg  <= 16'h0000;
          mul_cnt_reg  <= 4'd0;
          mul_seld_reg <= i_seld;
        end
      end else if (!(q_p_valid && i_p_stalled)) begin
        q_p_valid <= 1'b0;
        q_we      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prco_exec.sv
// tb_prco_exec: directed scenarios plus random instruction streams, each cycle
// compared against an instruction-level reference model of the exec stage.
module tb_prco_exec;
  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid;
  logic        p_stalled_in;
  logic [5:0]  op;
  logic [2:0]  seld;
  logic [15:0] da, db, imm;
  logic        q_p_stalled, q_p_valid, q_p_cp, q_we;
  logic [15:0] q_result, q_branch_pc;
  logic [2:0]  q_seld, q_flags;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_valid, m_we, m_cp;
  logic [15:0] m_result, m_bpc, m_prod;
  logic [2:0]  m_seld, m_flags, m_mseld;
  int          m_busy;

  always #5 clk = ~clk;

  prco_exec dut (
    .i_clk(clk), .i_reset(rst), .i_p_valid(p_valid), .q_p_stalled(q_p_stalled),
    .q_p_valid(q_p_valid), .i_p_stalled(p_stalled_in), .q_p_cp(q_p_cp),
    .i_op(op), .i_seld(seld), .i_data_a(da), .i_data_b(db), .i_imm8(imm),
    .q_result(q_result), .q_seld(q_seld), .q_we(q_we), .q_flags(q_flags),
    .q_branch_pc(q_branch_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_cp = 0; m_result = 0; m_bpc = 0; m_prod = 0;
    m_seld = 0; m_flags = 0; m_mseld = 0; m_busy = 0;
  endtask

  // Advance the model across one rising edge given the currently driven inputs.
  task automatic model_next();
    logic stl, acc, c, zn, cu, we, res, taken;
    int unsigned ua, ub, s, r;
    stl = (m_busy > 0) || (m_valid && p_stalled_in);
    acc = p_valid && !stl && !m_cp;
    m_cp = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1; m_we = 1; m_result = m_prod; m_seld = m_mseld;
        m_flags[2] = m_prod[15]; m_flags[0] = (m_prod == 16'h0);
      end
    end else if (acc) begin
      ua = da; ub = db; s = ub % 16; r = 0; c = 0;
      zn = 0; cu = 0; we = 0; res = 1; taken = 0;
      case (op)
        6'h01: begin r = imm; we = 1; end
        6'h02: begin r = ua + ub; c = (r > 32'hFFFF); zn = 1; cu = 1; we = 1; end
        6'h03: begin r = ua - ub; c = (ua < ub); zn = 1; cu = 1; we = 1; end
        6'h04: begin r = ua & ub; zn = 1; we = 1; end
        6'h05: begin r = ua | ub; zn = 1; we = 1; end
        6'h06: begin r = ua ^ ub; zn = 1; we = 1; end
        6'h07: begin r = ua << s; c = (s != 0) ? ((ua >> (16 - s)) & 1) : 0; zn = 1; cu = 1; we = 1; end
        6'h08: begin r = ua >> s; c = (s != 0) ? ((ua >> (s - 1)) & 1) : 0; zn = 1; cu = 1; we = 1; end
        6'h09: begin m_prod = 16'((ua * ub) & 32'hFFFF); m_busy = 17; m_mseld = seld; res = 0; end
        6'h0A: begin r = ua - ub; c = (ua < ub); zn = 1; cu = 1; end
        6'h0B: taken = 1;
        6'h0C: taken = m_flags[0];
        6'h0D: taken = !m_flags[0];
        default: ;
      endcase
      r = r & 32'hFFFF;
      if (taken) begin
        m_cp = 1; m_bpc = imm; m_valid = 0; m_we = 0;
      end else if (res) begin
        m_valid = 1; m_we = we;
        if (we) begin m_result = 16'(r); m_seld = seld; end
        if (zn) begin m_flags[2] = (r >= 32'h8000); m_flags[0] = (r == 0); end
        if (cu) m_flags[1] = c;
      end else begin
        m_valid = 0; m_we = 0;
      end
    end else if (!(m_valid && p_stalled_in)) begin
      m_valid = 0; m_we = 0;
    end
  endtask

  task automatic compare_all();
    check("stalled", q_p_stalled, (m_busy > 0) || (m_valid && p_stalled_in));
    check("valid", q_p_valid, m_valid);
    check("cp", q_p_cp, m_cp);
    check("flags", q_flags, m_flags);
    if (m_valid) check("we", q_we, m_we);
    if (m_valid && m_we) begin
      check("result", q_result, m_result);
      check("seld", q_seld, m_seld);
    end
    if (m_cp) check("branch_pc", q_branch_pc, m_bpc);
  endtask

  task automatic step(input logic v, input logic [5:0] o, input logic [2:0] sd,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] im,
                      input logic st);
    p_valid = v; op = o; seld = sd; da = a; db = b; imm = im; p_stalled_in = st;
    model_next();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'h00, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [2:0]  saved_flags;
    logic [5:0]  r_op;
    logic [15:0] r_a, r_b;
    rst = 1'b1; p_valid = 0; p_stalled_in = 0; op = 0; seld = 0; da = 0; db = 0; imm = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", q_p_valid, 1'b0);
    check("rst_stalled", q_p_stalled, 1'b0);
    check("rst_result", q_result, 16'h0000);
    check("rst_flags", q_flags, 3'b000);
    rst = 1'b0;
    idle(1);

    // ADD wraps to zero with carry out
    step(1'b1, 6'h02, 3'd3, 16'hFFFF, 16'h0001, 16'h0, 1'b0);
    $display("ADD FFFF+0001 -> valid=%0b result=%h we=%0b seld=%0d flags=%b", q_p_valid, q_result, q_we, q_seld, q_flags);
    check("add_valid", q_p_valid, 1'b1);
    check("add_result", q_result, 16'h0000);
    check("add_we", q_we, 1'b1);
    check("add_seld", q_seld, 3'd3);
    check("add_flags", q_flags, 3'b011);

    // MUL held on the input for its whole duration
    idle(1);
    step(1'b1, 6'h09, 3'd5, 16'h0123, 16'h0045, 16'h0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) check("mul_busy", q_p_stalled, 1'b1);
      step(1'b1, 6'h09, 3'd5, 16'h0123, 16'h0045, 16'h0, 1'b0);
    end
    $display("MUL 0123*0045 -> valid=%0b result=%h", q_p_valid, q_result);
    check("mul_result", q_result, 16'h4E6F);
    check("mul_valid", q_p_valid, 1'b1);
    idle(20);

    // CMP equal, JEQ taken back-to-back, wrong-path ADD squashed
    step(1'b1, 6'h0A, 3'd1, 16'd5, 16'd5, 16'h0, 1'b0);
    step(1'b1, 6'h0C, 3'd0, 16'h0, 16'h0, 16'h0040, 1'b0);
    $display("JEQ after CMP -> cp=%0b branch_pc=%h", q_p_cp, q_branch_pc);
    check("jeq_cp", q_p_cp, 1'b1);
    check("jeq_pc", q_branch_pc, 16'h0040);
    step(1'b1, 6'h02, 3'd2, 16'h1111, 16'h2222, 16'h0, 1'b0);
    check("squash_valid", q_p_valid, 1'b0);
    check("squash_cp", q_p_cp, 1'b0);
    idle(1);
    check("squash_after", q_p_valid, 1'b0);

    // SHL held by a stalled writeback stage
    step(1'b1, 6'h07, 3'd4, 16'h8001, 16'h0001, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      $display("SHL stall cycle %0d -> result=%h flags=%b stalled=%0b", i, q_result, q_flags, q_p_stalled);
      check("shl_result", q_result, 16'h0002);
      check("shl_c", q_flags[1], 1'b1);
      check("shl_stalled", q_p_stalled, 1'b1);
      step(1'b1, 6'h02, 3'd0, 16'h0, 16'h0, 16'h0, (i < 2));
    end
    idle(2);

    // reset in the middle of a MUL
    step(1'b1, 6'h09, 3'd6, 16'h00FF, 16'h0101, 16'h0, 1'b0);
    idle(8);
    #2 rst = 1'b1;
    #1;
    $display("reset mid-MUL -> valid=%0b stalled=%0b result=%h", q_p_valid, q_p_stalled, q_result);
    check("mrst_valid", q_p_valid, 1'b0);
    check("mrst_result", q_result, 16'h0000);
    check("mrst_we", q_we, 1'b0);
    check("mrst_flags", q_flags, 3'b000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check("mrst_stalled", q_p_stalled, 1'b0);
    idle(20);

    // undefined opcode behaves as NOP
    step(1'b1, 6'h03, 3'd1, 16'h0001, 16'h0002, 16'h0, 1'b0);
    saved_flags = m_flags;
    step(1'b1, 6'h3F, 3'd2, 16'h0001, 16'h0001, 16'h0, 1'b0);
    $display("OP 3F -> valid=%0b we=%0b flags=%b", q_p_valid, q_we, q_flags);
    check("nop_valid", q_p_valid, 1'b1);
    check("nop_we", q_we, 1'b0);
    check("nop_flags", q_flags, saved_flags);

    // random instruction stream
    for (int i = 0; i < 800; i++) begin
      r_op = 6'($urandom_range(0, 13));
      if (r_op == 6'h09 && ($urandom % 4) != 0) r_op = 6'h02;
      if (($urandom % 16) == 0) r_op = 6'h3F;
      r_a = 16'($urandom);
      r_b = (($urandom % 4) == 0) ? r_a : 16'($urandom);
      if (($urandom % 8) == 0) r_b = 16'h0000;
      step(($urandom % 4) != 0, r_op, 3'($urandom), r_a, r_b, 16'($urandom), ($urandom % 4) == 0);
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
